// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Boot sequencer that owns the instruction-memory write port while a program
//   is streamed in over the UART. Bytes are packed little-endian into 32-bit
//   words and written to consecutive imem word addresses. The core is held in
//   reset until the end-marker word arrives.
//
// Ports
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   loader_en            start loading (sampled only in IDLE)
//   rx_valid, rx_byte    one-cycle byte strobe from the UART receiver
//   loader_ready         high while the programmer may send (RECV)
//   imem_we/addr/wdata   imem write request, held until imem_ack
//   imem_ack             imem accepted the write this cycle
//   core_rst_n           core reset, released once loading is done
//   prog_done            load finished (sticky)
//   prog_err             sticky error: timeout, overrun or overflow
//   word_count           number of words written so far
module uart_prog_loader #(
    parameter int          ADDR_W   = 12,
    parameter int          DEPTH    = 4096,
    parameter logic [31:0] END_WORD = 32'h0000_0FFF,
    parameter int          TIMEOUT  = 50000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              loader_en,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              loader_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              core_rst_n,
    output logic              prog_done,
    output logic              prog_err,
    output logic [ADDR_W:0]   word_count
);

    localparam int                TO_W    = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CHECK,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       word;
    logic [1:0]        byte_cnt;
    logic [TO_W-1:0]   idle_cnt;
    logic              skid_vld;
    logic [7:0]        skid_byte;
    logic [ADDR_W:0]   wcnt;
    logic              err;
    logic [2:0]        byte_sum;
    logic              word_full;
    logic              skid_window;

    // In RECV up to two bytes can land in one cycle: the drained skid byte
    // followed by a fresh rx byte. byte_sum reaching 4 completes the word.
    assign byte_sum    = {1'b0, byte_cnt} + {2'b00, skid_vld} + {2'b00, rx_valid};
    assign word_full   = byte_sum[2];
    assign skid_window = (state == CHECK) || (state == WRITE);

    assign imem_addr  = wcnt[ADDR_W-1:0];
    assign imem_wdata = word;
    assign word_count = wcnt;
    assign prog_err   = err;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        state_nxt    = state;
        loader_ready = 1'b0;
        imem_we      = 1'b0;
        core_rst_n   = 1'b0;
        prog_done    = 1'b0;
        case (state)
            IDLE: begin
                if (loader_en) state_nxt = RECV;
            end
            RECV: begin
                loader_ready = 1'b1;
                if (word_full) state_nxt = CHECK;
            end
            CHECK: begin
                // The end marker takes priority over the overflow check so a
                // full memory followed by the marker finishes cleanly.
                if (word == END_WORD || wcnt == DEPTH_C) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                imem_we = 1'b1;
                if (imem_ack) state_nxt = RECV;
            end
            DONE: begin
                core_rst_n = 1'b1;
                prog_done  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte assembly, skid buffer, timeout and counters
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            word      <= '0;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            skid_vld  <= 1'b0;
            skid_byte <= '0;
            wcnt      <= '0;
            err       <= 1'b0;
        end else begin
            if (state == RECV) begin
                skid_vld <= 1'b0;
                if (skid_vld && rx_valid) begin
                    word <= {rx_byte, skid_byte, word[31:16]};
                end else if (skid_vld) begin
                    word <= {skid_byte, word[31:8]};
                end else if (rx_valid) begin
                    word <= {rx_byte, word[31:8]};
                end

                if (skid_vld || rx_valid) begin
                    byte_cnt <= byte_sum[1:0];
                    idle_cnt <= '0;
                end else if (byte_cnt != 2'd0) begin
                    // Stalled partial word: drop it after TIMEOUT idle cycles.
                    // The stale bytes in word are overwritten by the next four.
                    if (idle_cnt == TO_LAST) begin
                        byte_cnt <= '0;
                        idle_cnt <= '0;
                        err      <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end else begin
                    idle_cnt <= '0;
                end
            end

            // Bytes that arrive while a word is being checked or written.
            if (skid_window && rx_valid) begin
                if (!skid_vld) begin
                    skid_vld  <= 1'b1;
                    skid_byte <= rx_byte;
                end else begin
                    err <= 1'b1;
                end
            end

            if (state == CHECK && word != END_WORD && wcnt == DEPTH_C) begin
                err <= 1'b1;
            end

            if (state == WRITE && imem_ack) begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

endmodule
